// File: rtl/tdm_clock_gen.sv
// tdm_clock_gen: SCK / WS-FSYNC generator for I2S and TDM audio ports.
//   clk_i          system clock; every output is registered in this domain
//   rst_i          asynchronous active-high reset
//   en_i           run request, acted on in IDLE and at frame boundaries only
//   mode_i         0 = I2S half-frame WS, 1 = TDM one-SCK frame-sync pulse
//   sck_div_i      SCK period in clk_i cycles (values below 2 run as 2)
//   sck_o          serial bit clock
//   ws_o           word select / frame sync
//   sck_rise_o     strobe in the cycle sck_o goes 0->1
//   sck_fall_o     strobe in the cycle sck_o goes 1->0
//   frame_start_o  strobe in the first cycle of slot 0 bit 0
//   slot_idx_o     current slot
//   bit_idx_o      current bit within the slot
//   busy_o         generator running
module tdm_clock_gen #(
    parameter int   DIV_W     = 8,
    parameter int   NUM_SLOTS = 2,
    parameter int   SLOT_BITS = 32,
    parameter logic WS_POL    = 1'b0,
    localparam int  SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int  BW        = $clog2(SLOT_BITS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [DIV_W-1:0] sck_div_i,
    output logic             sck_o,
    output logic             ws_o,
    output logic             sck_rise_o,
    output logic             sck_fall_o,
    output logic             frame_start_o,
    output logic [SW-1:0]    slot_idx_o,
    output logic [BW-1:0]    bit_idx_o,
    output logic             busy_o
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, ph_q, ph_d, div_eff, lo, hi;
    logic             mode_q, mode_d, sck_q, sck_d, ws_q, ws_d;
    logic             rise_q, rise_d, fall_q, fall_d, fs_q, fs_d;
    logic [SW-1:0]    slot_q, slot_d, slot_n;
    logic [BW-1:0]    bit_q, bit_d, bit_n;
    logic             run, rise_now, fall_now, bit_wrap, slot_wrap, frame_end, start;
    assign run       = (state_q == RUN);
    assign div_eff   = (sck_div_i < DIV_W'(2)) ? DIV_W'(2) : sck_div_i;
    // low phase gets the odd cycle: ceil(D/2) low, floor(D/2) high
    assign lo        = DIV_W'(div_q[DIV_W-1:1]) + DIV_W'(div_q[0]);
    assign hi        = DIV_W'(div_q[DIV_W-1:1]);
    assign rise_now  = run && !sck_q && (ph_q == lo - DIV_W'(1));
    assign fall_now  = run && sck_q && (ph_q == hi - DIV_W'(1));
    assign bit_wrap  = (bit_q == BW'(SLOT_BITS - 1));
    assign slot_wrap = (slot_q == SW'(NUM_SLOTS - 1));
    assign frame_end = fall_now && bit_wrap && slot_wrap;
    // a frame starts from IDLE or at a boundary fall when still enabled
    assign start     = en_i && (!run || frame_end);
    assign bit_n     = bit_wrap ? '0 : bit_q + BW'(1);
    assign slot_n    = bit_wrap ? (slot_wrap ? '0 : slot_q + SW'(1)) : slot_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= DIV_W'(2);
            mode_q  <= 1'b0;
            ph_q    <= '0;
            sck_q   <= 1'b0;
            ws_q    <= ~WS_POL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fs_q    <= 1'b0;
            slot_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            ph_q    <= ph_d;
            sck_q   <= sck_d;
            ws_q    <= ws_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            fs_q    <= fs_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
        end
    end
    always_comb begin
        state_d = !run ? (en_i ? RUN : IDLE) : ((frame_end && !en_i) ? IDLE : RUN);
    end
    always_comb begin
        div_d  = start ? div_eff : div_q;
        mode_d = start ? mode_i : mode_q;
        ph_d   = '0;
        sck_d  = 1'b0;
        ws_d   = ~WS_POL;
        rise_d = 1'b0;
        fall_d = 1'b0;
        fs_d   = 1'b0;
        slot_d = '0;
        bit_d  = '0;
        if (start) begin
            ws_d   = WS_POL;
            fs_d   = 1'b1;
            fall_d = frame_end;
        end else if (state_d == RUN) begin
            ph_d   = (rise_now || fall_now) ? '0 : ph_q + DIV_W'(1);
            sck_d  = rise_now || (sck_q && !fall_now);
            rise_d = rise_now;
            fall_d = fall_now;
            slot_d = fall_now ? slot_n : slot_q;
            bit_d  = fall_now ? bit_n : bit_q;
            // in TDM mode every non-boundary fall ends the sync pulse
            ws_d   = !fall_now ? ws_q :
                     (mode_q ? ~WS_POL : ((slot_n < SW'(NUM_SLOTS / 2)) ? WS_POL : ~WS_POL));
        end
    end
    assign sck_o         = sck_q;
    assign ws_o          = ws_q;
    assign sck_rise_o    = rise_q;
    assign sck_fall_o    = fall_q;
    assign frame_start_o = fs_q;
    assign slot_idx_o    = slot_q;
    assign bit_idx_o     = bit_q;
    assign busy_o        = run;
endmodule

// File: tb/tb_tdm_clock_gen.sv
// tb_tdm_clock_gen: directed bench for tdm_clock_gen (I2S instance and 8x16 TDM instance).
module tb_tdm_clock_gen;
    logic       clk = 1'b0, rst = 1'b1;
    logic       en0 = 1'b0, mode0 = 1'b0, en1 = 1'b0, mode1 = 1'b0;
    logic [7:0] div0 = 8'd8, div1 = 8'd4;
    logic       sck0, ws0, rise0, fall0, fs0, busy0;
    logic       sck1, ws1, rise1, fall1, fs1, busy1;
    logic [0:0] slot0;
    logic [4:0] bit0;
    logic [2:0] slot1;
    logic [3:0] bit1;
    int total = 0, bad = 0, t = 0;

    always #5 clk = ~clk;

    tdm_clock_gen u0 (
        .clk_i(clk), .rst_i(rst), .en_i(en0), .mode_i(mode0), .sck_div_i(div0),
        .sck_o(sck0), .ws_o(ws0), .sck_rise_o(rise0), .sck_fall_o(fall0),
        .frame_start_o(fs0), .slot_idx_o(slot0), .bit_idx_o(bit0), .busy_o(busy0)
    );

    tdm_clock_gen #(.DIV_W(8), .NUM_SLOTS(8), .SLOT_BITS(16), .WS_POL(1'b1)) u1 (
        .clk_i(clk), .rst_i(rst), .en_i(en1), .mode_i(mode1), .sck_div_i(div1),
        .sck_o(sck1), .ws_o(ws1), .sck_rise_o(rise1), .sck_fall_o(fall1),
        .frame_start_o(fs1), .slot_idx_o(slot1), .bit_idx_o(bit1), .busy_o(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic to_t(input int n);
        while (t < n) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst sck0", 32'(sck0), 0);
        chk("rst ws0", 32'(ws0), 1);
        chk("rst ws1", 32'(ws1), 0);
        chk("rst busy0", 32'(busy0), 0);
        chk("rst fs0", 32'(fs0), 0);
        chk("rst slot1", 32'(slot1), 0);
        chk("rst bit0", 32'(bit0), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle busy0", 32'(busy0), 0);
        chk("idle fs0", 32'(fs0), 0);
        chk("idle rise0", 32'(rise0), 0);
        en0 = 1'b1; div0 = 8'd8; mode0 = 1'b0;
        en1 = 1'b1; div1 = 8'd4; mode1 = 1'b1;
        t = -1;
        to_t(0);
        chk("start fs0", 32'(fs0), 1);
        chk("start sck0", 32'(sck0), 0);
        chk("start ws0", 32'(ws0), 0);
        chk("start busy0", 32'(busy0), 1);
        chk("start fall0", 32'(fall0), 0);
        chk("start fs1", 32'(fs1), 1);
        chk("start ws1", 32'(ws1), 1);
        to_t(2);
        chk("u1 rise d4", 32'(rise1), 1);
        to_t(3);
        chk("d8 low end sck0", 32'(sck0), 0);
        chk("u1 ws pulse end", 32'(ws1), 1);
        to_t(4);
        chk("d8 rise0", 32'(rise0), 1);
        chk("d8 sck0 high", 32'(sck0), 1);
        chk("u1 ws after pulse", 32'(ws1), 0);
        chk("u1 fall", 32'(fall1), 1);
        to_t(5);
        chk("d8 rise0 single", 32'(rise0), 0);
        to_t(8);
        chk("d8 fall0", 32'(fall0), 1);
        chk("d8 bit0 1", 32'(bit0), 1);
        chk("d8 fs0 off", 32'(fs0), 0);
        to_t(64);
        chk("u1 slot 1", 32'(slot1), 1);
        chk("u1 bit 0", 32'(bit1), 0);
        to_t(255);
        chk("half ws0", 32'(ws0), 0);
        chk("half bit0", 32'(bit0), 31);
        to_t(256);
        chk("slot1 ws0", 32'(ws0), 1);
        chk("slot1 slot0", 32'(slot0), 1);
        chk("slot1 bit0", 32'(bit0), 0);
        to_t(448);
        chk("u1 slot 7", 32'(slot1), 7);
        to_t(511);
        chk("u1 last bit", 32'(bit1), 15);
        chk("end ws0", 32'(ws0), 1);
        to_t(512);
        chk("frame2 fs0", 32'(fs0), 1);
        chk("frame2 fall0", 32'(fall0), 1);
        chk("frame2 ws0", 32'(ws0), 0);
        chk("frame2 slot0", 32'(slot0), 0);
        chk("frame2 fs1", 32'(fs1), 1);
        chk("frame2 ws1", 32'(ws1), 1);
        to_t(516);
        chk("frame2 ws1 end", 32'(ws1), 0);
        to_t(600);
        div0 = 8'd6; mode0 = 1'b1;
        to_t(700);
        chk("mid mode held ws0", 32'(ws0), 0);
        to_t(1020);
        chk("mid div held rise0", 32'(rise0), 1);
        to_t(1024);
        chk("new frame fs0", 32'(fs0), 1);
        chk("new frame ws0", 32'(ws0), 0);
        to_t(1027);
        chk("d6 rise0", 32'(rise0), 1);
        to_t(1029);
        chk("m1 ws0 pulse", 32'(ws0), 0);
        to_t(1030);
        chk("d6 fall0", 32'(fall0), 1);
        chk("m1 ws0 after", 32'(ws0), 1);
        to_t(1100);
        div0 = 8'd5; mode0 = 1'b0;
        to_t(1407);
        chk("d6 frame end fs0", 32'(fs0), 0);
        to_t(1408);
        chk("d5 fs0", 32'(fs0), 1);
        to_t(1410);
        chk("d5 low 3 sck0", 32'(sck0), 0);
        to_t(1411);
        chk("d5 rise0", 32'(rise0), 1);
        to_t(1412);
        chk("d5 high sck0", 32'(sck0), 1);
        to_t(1413);
        chk("d5 fall0", 32'(fall0), 1);
        chk("d5 bit0", 32'(bit0), 1);
        to_t(1418);
        chk("d5 fall0 again", 32'(fall0), 1);
        chk("d5 bit0 2", 32'(bit0), 2);
        to_t(1500);
        div0 = 8'd0;
        to_t(1728);
        chk("d0 fs0", 32'(fs0), 1);
        chk("d0 sck0", 32'(sck0), 0);
        to_t(1729);
        chk("d0 rise0", 32'(rise0), 1);
        to_t(1730);
        chk("d0 fall0", 32'(fall0), 1);
        chk("d0 bit0", 32'(bit0), 1);
        to_t(1926);
        chk("drop point slot0", 32'(slot0), 1);
        chk("drop point bit0", 32'(bit0), 3);
        en0 = 1'b0;
        to_t(1983);
        chk("drain busy0", 32'(busy0), 1);
        chk("drain bit0", 32'(bit0), 31);
        chk("drain sck0", 32'(sck0), 1);
        to_t(1984);
        chk("idle busy0 after", 32'(busy0), 0);
        chk("idle sck0 after", 32'(sck0), 0);
        chk("idle ws0 after", 32'(ws0), 1);
        chk("idle fs0 after", 32'(fs0), 0);
        chk("idle fall0 after", 32'(fall0), 0);
        to_t(1990);
        chk("idle still", 32'(busy0), 0);
        en0 = 1'b1; div0 = 8'd8;
        to_t(1991);
        chk("rearm fs0", 32'(fs0), 1);
        chk("rearm busy0", 32'(busy0), 1);
        to_t(1996);
        chk("pre-rst sck0", 32'(sck0), 1);
        #2 rst = 1'b1;
        #1;
        chk("async sck0", 32'(sck0), 0);
        chk("async busy0", 32'(busy0), 0);
        chk("async ws0", 32'(ws0), 1);
        chk("async slot1", 32'(slot1), 0);
        chk("async ws1", 32'(ws1), 0);
        to_t(1997);
        rst = 1'b0;
        to_t(1998);
        chk("post-rst fs0", 32'(fs0), 1);
        chk("post-rst bit0", 32'(bit0), 0);
        chk("post-rst slot0", 32'(slot0), 0);
        chk("post-rst fs1", 32'(fs1), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tdm_clock_gen.md
Name: tdm_clock_gen

Overview:
Parametrised successor to the fixed I2S SCK/WS generator, and the master clock source for multi-channel audio.
- Produces SCK, WS/FSYNC and per-bit timing strobes for the serializer/deserializer.
- Supports run-time divider, enable and mode (I2S 50%-duty WS or TDM one-SCK frame-sync pulse).
- Slot count and slot width are parametrised.
- Sits between the system clock domain and the audio ports; all outputs are registered in clk_i.

Parameters:
DIV_W, 8, width of run-time SCK divider input
NUM_SLOTS, 2, channel slots per frame (>=2; must be even for mode 0)
SLOT_BITS, 32, SCK cycles per slot (>=2)
WS_POL, 1'b0, WS level for first half-frame (mode 0) and for the sync pulse (mode 1)

Ports:
clk_i  in  1  system clock (27 MHz)
rst_i  in  1  asynchronous active-high reset
en_i  in  1  run request
mode_i  in  1  0 = I2S/half-frame WS, 1 = TDM pulse FSYNC
sck_div_i  in  DIV_W  SCK period in clk_i cycles; values <2 are treated as 2
sck_o  out  1  serial bit clock
ws_o  out  1  word select / frame sync
sck_rise_o  out  1  one-cycle strobe, cycle sck_o goes 0->1
sck_fall_o  out  1  one-cycle strobe, cycle sck_o goes 1->0
frame_start_o  out  1  one-cycle strobe, first cycle of slot 0 bit 0
slot_idx_o  out  max(1,$clog2(NUM_SLOTS))  current slot
bit_idx_o  out  $clog2(SLOT_BITS)  current bit within slot
busy_o  out  1  generator running

Behaviour:
- Reset, asynchronous and active-high: sck_o=0, ws_o=~WS_POL, all strobes 0, slot_idx_o=0, bit_idx_o=0, busy_o=0, divider and mode registers=2 and 0.
- States: IDLE, RUN.
- IDLE:
  - Outputs hold their reset values.
  - en_i sampled 1 → next cycle enters RUN and latches sck_div_i and mode_i.
  - That cycle shows frame_start_o=1, sck_o=0, slot/bit=0, and ws_o at its frame-start level.
- SCK timing, with D = latched divider:
  - Low phase is ceil(D/2) cycles, high phase is floor(D/2) cycles; the low phase comes first.
  - The frame-start cycle counts as the first low cycle.
  - A phase counter of DIV_W bits resets on each SCK edge.
- Bit advance on every fall (the cycle sck_o returns to 0):
  - bit_idx_o increments.
  - On wrap SLOT_BITS-1→0, slot_idx_o increments.
  - On slot wrap NUM_SLOTS-1→0, this is a frame boundary and frame_start_o=1 in the same cycle.
- ws_o changes only in frame-start or fall cycles (registered, coincident with sck_o falling).
  - mode 0: ws_o=WS_POL while slot_idx < NUM_SLOTS/2, else ~WS_POL.
  - mode 1: ws_o=WS_POL for the first SCK period of the frame (until the next fall), else ~WS_POL.
- Frame boundary, while in RUN:
  - en_i=1: re-latch sck_div_i and mode_i; the new values apply from this frame-start cycle.
  - en_i=0: enter IDLE instead. That cycle has sck_o=0, ws_o=~WS_POL, busy_o=0, and no frame_start_o.
  - Changes to en_i, mode_i or sck_div_i mid-frame have no effect until the boundary. Frames are always complete.
- Strobes:
  - sck_rise_o and sck_fall_o never assert in IDLE.
  - The initial frame-start from IDLE is not a fall strobe.
- Reset mid-frame: immediate return to reset values; no partial-frame completion.
- busy_o=1 in every RUN cycle.

Test Plan:
1. D=8, NUM_SLOTS=2, SLOT_BITS=32, mode 0, en held → SCK 4 low/4 high; frame_start_o every 512 clk_i cycles; ws_o=WS_POL for 256 cycles then ~WS_POL for 256 cycles; bit_idx 0..31 twice per frame.
2. D=5 → low 3 cycles, high 2 cycles; one fall strobe per 5 cycles; sck_div_i=0 or 1 → period 2 (1 low, 1 high).
3. mode 1, NUM_SLOTS=8, SLOT_BITS=16, D=4 → frame 512 cycles; ws_o=WS_POL for exactly 4 cycles starting at frame_start_o; slot_idx_o steps 0..7 every 64 cycles.
4. Change sck_div_i 8→6 and mode_i 0→1 mid-frame → current frame completes at D=8 in mode 0; the next frame_start cycle begins D=6 in mode 1.
5. Drop en_i at bit 3 of slot 1 → generator runs to the end of slot 1 bit 31; at the next fall, IDLE with sck_o=0, ws_o=~WS_POL, busy_o=0 and no frame_start_o; re-raise en_i → frame_start_o the following cycle.
6. Assert rst_i asynchronously mid-high-phase → outputs at reset values before the next clk_i edge; after release with en_i=1, a clean frame start with slot/bit=0.
